ahb_sram_subordinate: RTL and testbench

- AHB-Lite subordinate wrapping a register-array SRAM with configurable wait states and two-cycle ERROR response.
- Sits directly upstream of the response mux: one instance per subordinate slot drives the HRDATAx/HRESPx/HREADYx inputs of that slot.
- Takes its select from the address decoder and the global HREADY back from the mux output.

---
 rtl/ahb_pkg.sv | 31 +++
 rtl/ahb_byte_strobe.sv | 20 ++
 rtl/ahb_sram_subordinate.sv | 161 ++++++++++++++++
 tb/tb_ahb_sram_subordinate.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM subordinate state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    RESP_OKAY  = 2'b00,
    RESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [2:0] {
    SIZE_BYTE  = 3'b000,
    SIZE_HALF  = 3'b001,
    SIZE_WORD  = 3'b010,
    SIZE_DWORD = 3'b011
  } hsize_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LAST,
    ST_ERR1,
    ST_ERR2
  } state_e;

endpackage

// File: rtl/ahb_byte_strobe.sv
// Byte-lane enables for an AHB transfer: a lane is active when it falls in the
// same size-aligned block as the transfer address.
module ahb_byte_strobe #(
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned NB         = DATA_WIDTH / 8,
  localparam int unsigned LW         = $clog2(NB)
) (
  input  logic [2:0]    i_size,
  input  logic [LW-1:0] i_addr_lo,
  output logic [NB-1:0] o_strb
);

  always_comb begin
    o_strb = '0;
    for (int i = 0; i < NB; i++) begin
      o_strb[i] = ((LW'(i) >> i_size) == (i_addr_lo >> i_size));
    end
  end

endmodule

// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite subordinate around a register-array SRAM with programmable
// data-phase wait states and the two-cycle ERROR response.
module ahb_sram_subordinate
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned REGION_BITS = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP
);

  localparam int unsigned NB        = DATA_WIDTH / 8;
  localparam int unsigned LW        = $clog2(NB);
  localparam int unsigned IW        = $clog2(MEM_DEPTH);
  localparam int unsigned MEM_BYTES = MEM_DEPTH * NB;
  localparam logic [REGION_BITS:0] REGION_LIMIT = (REGION_BITS + 1)'(MEM_BYTES);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_nxt;
  logic [IW-1:0]         r_idx;
  logic [LW-1:0]         r_lane;
  logic [2:0]            r_size;
  logic                  r_write;
  logic                  r_hreadyout;
  logic [1:0]            r_hresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                  w_accept;
  logic                  w_cap;
  logic                  w_err;
  logic [7:0]            w_align_mask;
  logic [IW-1:0]         w_addr_idx;
  logic [IW-1:0]         w_rd_idx;
  logic                  w_wr_en;
  logic                  w_fwd;
  logic                  w_write_nxt;
  logic [NB-1:0]         w_strb;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  w_unused;

  assign w_unused = ^{HBURST, HPROT, HTRANS[0], HADDR};

  assign w_accept     = HSEL && HREADY && HTRANS[1];
  assign w_addr_idx   = HADDR[IW+LW-1:LW];
  assign w_align_mask = (8'd1 << HSIZE) - 8'd1;
  assign w_err        = ({1'b0, HADDR[REGION_BITS-1:0]} >= REGION_LIMIT)
                     || (HSIZE > 3'(LW))
                     || (|(HADDR[7:0] & w_align_mask));

  // Lane enables of the transfer currently in its data phase
  ahb_byte_strobe #(.DATA_WIDTH(DATA_WIDTH)) u_strobe (
    .i_size    (r_size),
    .i_addr_lo (r_lane),
    .o_strb    (w_strb)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cap       = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_LAST, ST_ERR2: begin
        if (w_accept) begin
          w_cap = 1'b1;
          if (w_err) begin
            w_state_nxt = ST_ERR1;
          end else if (WAIT_STATES == 0) begin
            w_state_nxt = ST_LAST;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = 4'(WAIT_STATES);
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_state_nxt = ST_LAST;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_ERR1: w_state_nxt = ST_ERR2;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A read entering LAST on the same edge a write commits sees the new bytes
  assign w_wr_en     = (r_state == ST_LAST) && r_write;
  assign w_rd_idx    = w_cap ? w_addr_idx : r_idx;
  assign w_fwd       = w_wr_en && (w_rd_idx == r_idx);
  assign w_write_nxt = w_cap ? HWRITE : r_write;

  always_comb begin
    w_rd_word = r_mem[w_rd_idx];
    for (int b = 0; b < NB; b++) begin
      if (w_fwd && w_strb[b]) w_rd_word[8*b +: 8] = HWDATA[8*b +: 8];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_lane      <= '0;
      r_size      <= SIZE_BYTE;
      r_write     <= 1'b0;
      r_hreadyout <= 1'b1;
      r_hresp     <= RESP_OKAY;
      r_rdata     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_cap) begin
        r_idx   <= w_addr_idx;
        r_lane  <= HADDR[LW-1:0];
        r_size  <= HSIZE;
        r_write <= HWRITE;
      end
      r_hreadyout <= !(w_state_nxt inside {ST_WAIT, ST_ERR1});
      r_hresp     <= (w_state_nxt inside {ST_ERR1, ST_ERR2}) ? RESP_ERROR : RESP_OKAY;
      r_rdata     <= ((w_state_nxt == ST_LAST) && !w_write_nxt) ? w_rd_word : '0;
    end
  end

  // Storage is intentionally not reset
  always_ff @(posedge HCLK) begin
    if (w_wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (w_strb[b]) r_mem[r_idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HRDATA    = r_rdata;
  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Bench for ahb_sram_subordinate: one zero-wait and one two-wait instance
// behind a shared bus, checked against a byte-lane memory model.
module tb_ahb_sram_subordinate;

  logic        HCLK    = 1'b0;
  logic        HRESETn = 1'b0;
  logic        bus_sel = 1'b0;
  logic        sel     = 1'b0;
  logic [31:0] HADDR   = '0;
  logic [1:0]  HTRANS  = 2'b00;
  logic        HWRITE  = 1'b0;
  logic [2:0]  HSIZE   = 3'd2;
  logic [31:0] HWDATA  = '0;

  logic [31:0] rd0, rd2, obs_rdata;
  logic        ro0, ro2, HREADY;
  logic [1:0]  rs0, rs2, obs_resp;
  logic        hsel0, hsel2;

  always #5 HCLK = ~HCLK;

  assign hsel0     = bus_sel & ~sel;
  assign hsel2     = bus_sel & sel;
  assign HREADY    = sel ? ro2 : ro0;
  assign obs_rdata = sel ? rd2 : rd0;
  assign obs_resp  = sel ? rs2 : rs0;

  ahb_sram_subordinate #(.WAIT_STATES(0)) dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(3'b000), .HPROT(4'b0011), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0)
  );

  ahb_sram_subordinate #(.WAIT_STATES(2)) dut2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel2), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(3'b001), .HPROT(4'b0011), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(rd2), .HREADYOUT(ro2), .HRESP(rs2)
  );

  typedef struct packed {
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [95:0] tag;
  } stim_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic [3:0]  waits;
    logic [95:0] tag;
  } exp_t;

  stim_t       stim_q[$];
  exp_t        exp_q[$];
  logic [31:0] model [2][256];
  int          n_checks = 0;
  int          n_err    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic add(input logic [1:0] tr, input logic wr, input logic [31:0] a,
                     input logic [2:0] sz, input logic [31:0] wd, input logic [95:0] tag);
    stim_t s;
    s = '{trans: tr, wr: wr, addr: a, size: sz, wdata: wd, tag: tag};
    stim_q.push_back(s);
  endtask

  // Expected response of an accepted address phase; applies writes to the model
  function automatic exp_t predict(input stim_t s);
    exp_t        e;
    int          nb;
    int          lo;
    int          idx;
    logic [31:0] w;
    e = '{wr: s.wr, wdata: s.wdata, rdata: 32'h0, resp: 2'b00, waits: 4'd0, tag: s.tag};
    if (s.trans[1]) begin
      nb  = 1 << s.size;
      lo  = int'(s.addr[1:0]);
      idx = int'(s.addr[9:2]);
      if (s.addr[15:0] >= 16'd1024 || s.size > 3'd2 || (int'(s.addr[2:0]) % nb) != 0) begin
        e.resp  = 2'b01;
        e.waits = 4'd1;
      end else begin
        e.waits = sel ? 4'd2 : 4'd0;
        if (s.wr) begin
          w = model[sel][idx];
          for (int b = 0; b < 4; b++) begin
            if (b >= lo && b < lo + nb) w[8*b +: 8] = s.wdata[8*b +: 8];
          end
          model[sel][idx] = w;
        end else begin
          e.rdata = model[sel][idx];
        end
      end
    end
    return e;
  endfunction

  // Pipelined master: called and returns at #1 after a rising edge
  task automatic run_q();
    int    cyc   = 0;
    int    waits = 0;
    stim_t s;
    exp_t  e;
    while ((stim_q.size() != 0 || exp_q.size() != 0) && cyc < 500) begin
      if (stim_q.size() != 0) begin
        s = stim_q[0];
        bus_sel = 1'b1; HTRANS = s.trans; HWRITE = s.wr; HADDR = s.addr; HSIZE = s.size;
      end else begin
        bus_sel = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
      end
      HWDATA = (exp_q.size() != 0 && exp_q[0].wr) ? exp_q[0].wdata : 32'h0;
      @(negedge HCLK);
      if (exp_q.size() != 0) begin
        if (HREADY) begin
          e = exp_q.pop_front();
          check($sformatf("%s rdata", e.tag), obs_rdata, e.rdata);
          check($sformatf("%s resp", e.tag), 32'(obs_resp), 32'(e.resp));
          check($sformatf("%s waits", e.tag), 32'(waits), 32'(e.waits));
          waits = 0;
        end else begin
          waits++;
          check($sformatf("%s wait resp", exp_q[0].tag), 32'(obs_resp), 32'(exp_q[0].resp));
          check($sformatf("%s wait rdata", exp_q[0].tag), obs_rdata, 32'h0);
        end
      end
      if (HREADY && stim_q.size() != 0) begin
        s = stim_q.pop_front();
        exp_q.push_back(predict(s));
      end
      @(posedge HCLK); #1;
      cyc++;
    end
    check("queues drained", 32'(stim_q.size() + exp_q.size()), 32'h0);
    bus_sel = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h0;
  endtask

  initial begin
    repeat (2) @(posedge HCLK);
    #1;
    check("reset ready0", 32'(ro0), 32'd1);
    check("reset resp0", 32'(rs0), 32'd0);
    check("reset rdata0", rd0, 32'h0);
    check("reset ready2", 32'(ro2), 32'd1);
    check("reset resp2", 32'(rs2), 32'd0);
    check("reset rdata2", rd2, 32'h0);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Zero-wait instance: back-to-back traffic, byte lanes, errors, idle/busy
    sel = 1'b0;
    add(2'b10, 1'b1, 32'h10,  3'd2, 32'hDEADBEEF, "w0_word");
    add(2'b10, 1'b0, 32'h10,  3'd2, 32'h0,        "r0_word");
    add(2'b10, 1'b1, 32'h11,  3'd0, 32'h0000AA00, "w0_byte");
    add(2'b10, 1'b0, 32'h10,  3'd2, 32'h0,        "r0_merge");
    add(2'b10, 1'b0, 32'h400, 3'd2, 32'h0,        "r0_range");
    add(2'b10, 1'b1, 32'h13,  3'd1, 32'hFFFF0000, "w0_misal");
    add(2'b11, 1'b0, 32'h10,  3'd2, 32'h0,        "r0_after");
    add(2'b10, 1'b0, 32'h18,  3'd3, 32'h0,        "r0_dword");
    add(2'b00, 1'b1, 32'h10,  3'd2, 32'h11111111, "i0_idle");
    add(2'b01, 1'b1, 32'h10,  3'd2, 32'h22222222, "i0_busy");
    add(2'b10, 1'b0, 32'h10,  3'd2, 32'h0,        "r0_kept");
    add(2'b10, 1'b1, 32'h3FC, 3'd2, 32'hCAFEF00D, "w0_top");
    add(2'b10, 1'b0, 32'h3FC, 3'd2, 32'h0,        "r0_top");
    add(2'b10, 1'b1, 32'h16,  3'd1, 32'h5A5A0000, "w0_half");
    add(2'b10, 1'b0, 32'h14,  3'd2, 32'h0,        "r0_half");
    run_q();

    // Two-wait instance
    sel = 1'b1;
    add(2'b10, 1'b1, 32'h10,  3'd2, 32'hDEADBEEF, "w2_word");
    add(2'b10, 1'b1, 32'h11,  3'd0, 32'h0000AA00, "w2_byte");
    add(2'b10, 1'b0, 32'h10,  3'd2, 32'h0,        "r2_merge");
    add(2'b10, 1'b0, 32'h400, 3'd2, 32'h0,        "r2_range");
    add(2'b10, 1'b1, 32'h13,  3'd1, 32'hFFFF0000, "w2_misal");
    add(2'b10, 1'b0, 32'h10,  3'd2, 32'h0,        "r2_after");
    add(2'b00, 1'b1, 32'h10,  3'd2, 32'h11111111, "i2_idle");
    add(2'b01, 1'b0, 32'h10,  3'd2, 32'h0,        "i2_busy");
    add(2'b10, 1'b0, 32'h10,  3'd2, 32'h0,        "r2_kept");
    run_q();

    // Reset while a write sits in WAIT
    sel = 1'b1;
    bus_sel = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h20; HSIZE = 3'd2;
    @(posedge HCLK); #1;
    bus_sel = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h12345678;
    check("rst in wait ready", 32'(ro2), 32'd0);
    HRESETn = 1'b0;
    #1;
    check("rst async ready", 32'(ro2), 32'd1);
    check("rst async resp", 32'(rs2), 32'd0);
    check("rst async rdata", rd2, 32'h0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    HWDATA  = 32'h0;
    @(posedge HCLK); #1;
    add(2'b10, 1'b1, 32'h20, 3'd2, 32'h0, "w2_post");
    add(2'b10, 1'b0, 32'h20, 3'd2, 32'h0, "r2_post");
    add(2'b10, 1'b0, 32'h10, 3'd2, 32'h0, "r2_retain");
    run_q();

    // Memory survives reset in the zero-wait instance too
    sel = 1'b0;
    add(2'b10, 1'b0, 32'h10,  3'd2, 32'h0, "r0_retain");
    add(2'b10, 1'b0, 32'h3FC, 3'd2, 32'h0, "r0_top_ret");
    run_q();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
